otter_hazard_ctrl: RTL and testbench

Hazard controller for the 5-stage pipelined OTTER (IF, DE, EX, MEM, WB). It keeps its own shadow scoreboard of in-flight destination registers and uses it to sequence the pipeline. Its outputs are PC and IF/DE stall, DE/EX bubble insertion, IF/DE flush after a taken branch or jump, and registered operand-forwarding selects for the ALU inputs in EX. It sits beside the decode stage and drives the `PC_WRITE` and pipeline-register enables that are hard-wired high today.

---
 rtl/otter_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_otter_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_hazard_ctrl.sv
// Hazard controller for the 5-stage OTTER: shadow scoreboard, stall/flush/bubble control, forwarding selects.
// Build option: define OTTER_HAZARD_FWD_EN for operand forwarding; otherwise RAW hazards stall until the writer retires.
module otter_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE_VALID,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       DE_RD_ADDR,
  input  logic             DE_REG_WRITE,
  input  logic             DE_MEM_READ,
  input  logic             EX_REDIRECT,
  output logic             PC_WRITE,
  output logic             IF_DE_WRITE,
  output logic             IF_DE_FLUSH,
  output logic             DE_EX_BUBBLE,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic             DBG_FLUSH_PEND
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;

  // Shadow stages; only ex needs memRead, since load-use is detected one stage behind DE.
  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_rw, mem_rw, wb_rw;
  logic       ex_mr;

  logic ex_wr, mem_wr, wb_wr;
  logic rs1_ex, rs1_mem, rs1_wb;
  logic rs2_ex, rs2_mem, rs2_wb;
  logic load_use, hazard, redirect, stall;

  assign ex_wr  = ex_v  & ex_rw  & (ex_rd  != 5'd0);
  assign mem_wr = mem_v & mem_rw & (mem_rd != 5'd0);
  assign wb_wr  = wb_v  & wb_rw  & (wb_rd  != 5'd0);

  assign rs1_ex  = DE_RS1_USED & ex_wr  & (DE_RS1_ADDR == ex_rd);
  assign rs1_mem = DE_RS1_USED & mem_wr & (DE_RS1_ADDR == mem_rd);
  assign rs1_wb  = DE_RS1_USED & wb_wr  & (DE_RS1_ADDR == wb_rd);
  assign rs2_ex  = DE_RS2_USED & ex_wr  & (DE_RS2_ADDR == ex_rd);
  assign rs2_mem = DE_RS2_USED & mem_wr & (DE_RS2_ADDR == mem_rd);
  assign rs2_wb  = DE_RS2_USED & wb_wr  & (DE_RS2_ADDR == wb_rd);

  assign load_use = DE_VALID & ex_mr & (rs1_ex | rs2_ex);

`ifdef OTTER_HAZARD_FWD_EN
  assign hazard = load_use;
`else
  assign hazard = load_use |
                  (DE_VALID & (rs1_ex | rs1_mem | rs1_wb | rs2_ex | rs2_mem | rs2_wb));
`endif

  // The second flush cycle kills the wrong-path word already fetched from synchronous imem.
  assign redirect = EX_REDIRECT | (state == ST_FLUSH);
  assign stall    = RESET & hazard & ~redirect;

  assign DBG_FLUSH_PEND = (state == ST_FLUSH);

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (EX_REDIRECT) state_nxt = ST_FLUSH;
  end

  // Enables are level signals: a register stage advances on any clock where its enable is high.
  always_comb begin
    PC_WRITE     = 1'b1;
    IF_DE_WRITE  = 1'b1;
    IF_DE_FLUSH  = 1'b0;
    DE_EX_BUBBLE = 1'b0;
    if (!RESET) begin
      IF_DE_FLUSH  = 1'b1;
      DE_EX_BUBBLE = 1'b1;
    end else if (redirect) begin
      IF_DE_FLUSH  = 1'b1;
      DE_EX_BUBBLE = 1'b1;
    end else if (hazard) begin
      PC_WRITE     = 1'b0;
      IF_DE_WRITE  = 1'b0;
      DE_EX_BUBBLE = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ex_v   <= 1'b0;
      mem_v  <= 1'b0;
      wb_v   <= 1'b0;
      ex_rd  <= 5'd0;
      mem_rd <= 5'd0;
      wb_rd  <= 5'd0;
      ex_rw  <= 1'b0;
      mem_rw <= 1'b0;
      wb_rw  <= 1'b0;
      ex_mr  <= 1'b0;
    end else begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      ex_v   <= DE_VALID & ~DE_EX_BUBBLE;
      ex_rd  <= DE_RD_ADDR;
      ex_rw  <= DE_REG_WRITE;
      ex_mr  <= DE_MEM_READ;
    end
  end

`ifdef OTTER_HAZARD_FWD_EN
  function automatic logic [1:0] fwd_code(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb);
    if (hit_ex)  return 2'b01;
    if (hit_mem) return 2'b10;
    if (hit_wb)  return 2'b11;
    return 2'b00;
  endfunction

  logic [1:0] sel_a_nxt, sel_b_nxt;

  always_comb begin
    sel_a_nxt = 2'b00;
    sel_b_nxt = 2'b00;
    if (DE_VALID && !DE_EX_BUBBLE) begin
      sel_a_nxt = fwd_code(rs1_ex, rs1_mem, rs1_wb);
      sel_b_nxt = fwd_code(rs2_ex, rs2_mem, rs2_wb);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      FWD_A_SEL <= 2'b00;
      FWD_B_SEL <= 2'b00;
    end else begin
      FWD_A_SEL <= sel_a_nxt;
      FWD_B_SEL <= sel_b_nxt;
    end
  end
`else
  assign FWD_A_SEL = 2'b00;
  assign FWD_B_SEL = 2'b00;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (stall && STALL_CNT != CNT_MAX)       STALL_CNT <= STALL_CNT + CNT_ONE;
      if (EX_REDIRECT && FLUSH_CNT != CNT_MAX) FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Self-checking bench for otter_hazard_ctrl: scenario tasks plus randomized traffic against an issue-history model.
module tb_otter_hazard_ctrl;

  localparam int TB_CNT_W = 8;

  logic                CLK;
  logic                RESET;
  logic                DE_VALID;
  logic [4:0]          DE_RS1_ADDR, DE_RS2_ADDR, DE_RD_ADDR;
  logic                DE_RS1_USED, DE_RS2_USED, DE_REG_WRITE, DE_MEM_READ;
  logic                EX_REDIRECT;
  logic                PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE;
  logic [1:0]          FWD_A_SEL, FWD_B_SEL;
  logic [TB_CNT_W-1:0] STALL_CNT, FLUSH_CNT;
  logic                DBG_FLUSH_PEND;

  otter_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .DE_VALID(DE_VALID),
    .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .DE_RS1_USED(DE_RS1_USED), .DE_RS2_USED(DE_RS2_USED),
    .DE_RD_ADDR(DE_RD_ADDR), .DE_REG_WRITE(DE_REG_WRITE), .DE_MEM_READ(DE_MEM_READ),
    .EX_REDIRECT(EX_REDIRECT), .PC_WRITE(PC_WRITE), .IF_DE_WRITE(IF_DE_WRITE),
    .IF_DE_FLUSH(IF_DE_FLUSH), .DE_EX_BUBBLE(DE_EX_BUBBLE),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .DBG_FLUSH_PEND(DBG_FLUSH_PEND)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: history of the last three issue slots into EX, index 0 = youngest.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } slot_t;

  slot_t               hist[$];
  bit                  m_pend;
  logic [3:0]          m_sel;
  logic [TB_CNT_W-1:0] m_stall, m_flush;
  logic [3:0]          exp_ctl;   // {PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE}
  bit                  m_stall_now;
  logic [23:0]         obs, expv;

  function automatic bit reads_from(slot_t s, logic used, logic [4:0] rs);
    return s.v && s.rw && (s.rd != 5'd0) && used && (s.rd == rs);
  endfunction

  function automatic bit src_dep(int k);
    return reads_from(hist[k], DE_RS1_USED, DE_RS1_ADDR) ||
           reads_from(hist[k], DE_RS2_USED, DE_RS2_ADDR);
  endfunction

  function automatic logic [1:0] model_sel(logic used, logic [4:0] rs);
    logic [1:0] code;
    code = 2'b00;
    for (int k = 2; k >= 0; k--)
      if (reads_from(hist[k], used, rs)) code = 2'(k + 1);
    return code;
  endfunction

  function automatic void model_eval();
    bit hz, redir;
    redir = EX_REDIRECT || m_pend;
    hz = 1'b0;
    if (DE_VALID) begin
      if (hist[0].mr && src_dep(0)) hz = 1'b1;
`ifndef OTTER_HAZARD_FWD_EN
      for (int k = 0; k < 3; k++) if (src_dep(k)) hz = 1'b1;
`endif
    end
    m_stall_now = RESET && hz && !redir;
    if (!RESET)     exp_ctl = 4'b1111;
    else if (redir) exp_ctl = 4'b1111;
    else if (hz)    exp_ctl = 4'b0001;
    else            exp_ctl = 4'b1100;
  endfunction

  function automatic void model_update();
    slot_t s;
    if (!RESET) begin
      hist.delete();
      for (int k = 0; k < 3; k++) hist.push_back('0);
      m_pend  = 1'b0;
      m_sel   = 4'b0000;
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_sel = 4'b0000;
`ifdef OTTER_HAZARD_FWD_EN
      if (DE_VALID && !exp_ctl[0])
        m_sel = {model_sel(DE_RS1_USED, DE_RS1_ADDR), model_sel(DE_RS2_USED, DE_RS2_ADDR)};
`endif
      if (m_stall_now && m_stall != {TB_CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
      if (EX_REDIRECT && m_flush != {TB_CNT_W{1'b1}}) m_flush = m_flush + 1'b1;
      m_pend = EX_REDIRECT;
      s.v  = DE_VALID && !exp_ctl[0];
      s.rd = DE_RD_ADDR;
      s.rw = DE_REG_WRITE;
      s.mr = DE_MEM_READ;
      hist.push_front(s);
      void'(hist.pop_back());
    end
  endfunction

  // driver tasks
  task automatic drive(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                       input bit u2, input logic [4:0] rd, input bit rw, input bit mr,
                       input bit redir);
    DE_VALID = v; DE_RS1_ADDR = rs1; DE_RS1_USED = u1; DE_RS2_ADDR = rs2; DE_RS2_USED = u2;
    DE_RD_ADDR = rd; DE_REG_WRITE = rw; DE_MEM_READ = mr; EX_REDIRECT = redir;
    #1;
    model_eval();
    obs  = {PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE, FWD_A_SEL, FWD_B_SEL,
            STALL_CNT, FLUSH_CNT};
    expv = {exp_ctl, m_sel, m_stall, m_flush};
  endtask

  task automatic nop(input bit redir);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, redir);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, (i == 1));
      if (i > 0) begin
        total++;
        if (obs !== expv) begin
          bad++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, expv);
        end
      end
      tick();
    end
    RESET = 1'b1;
    nop(1'b0);
    total++;
    if ({IF_DE_FLUSH, DE_EX_BUBBLE, FWD_A_SEL, FWD_B_SEL, STALL_CNT, FLUSH_CNT} !== '0) begin
      bad++; $display("FAIL reset_release got=%b%b %b %b %h %h required=all zero",
                      IF_DE_FLUSH, DE_EX_BUBBLE, FWD_A_SEL, FWD_B_SEL, STALL_CNT, FLUSH_CNT);
    end
    tick();
  endtask

  task automatic test_load_use();
    int n; bit stalled; logic [TB_CNT_W-1:0] s0;
    s0 = m_stall;
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5,0(x2)
    total++;
    if (obs !== expv) begin bad++; $display("FAIL load_use_lw got=%h exp=%h", obs, expv); end
    tick();
    n = 0;
    do begin
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); // add x6,x5,x1
      total++;
      if (obs !== expv) begin bad++; $display("FAIL load_use_add n=%0d got=%h exp=%h", n, obs, expv); end
      stalled = exp_ctl[0];
      tick();
      n++;
    end while (stalled && n < 6);
    nop(1'b0);
    total++;
    if (obs !== expv) begin bad++; $display("FAIL load_use_ex got=%h exp=%h", obs, expv); end
`ifdef OTTER_HAZARD_FWD_EN
    total++;
    if ({n, FWD_A_SEL, STALL_CNT - s0} !== {32'd2, 2'b10, TB_CNT_W'(1)}) begin
      bad++; $display("FAIL load_use_spec cycles=%0d sel_a=%b stalls=%0d required 2/10/1",
                      n, FWD_A_SEL, STALL_CNT - s0);
    end
`else
    total++;
    if ({n, FWD_A_SEL, STALL_CNT - s0} !== {32'd4, 2'b00, TB_CNT_W'(3)}) begin
      bad++; $display("FAIL load_use_spec cycles=%0d sel_a=%b stalls=%0d required 4/00/3",
                      n, FWD_A_SEL, STALL_CNT - s0);
    end
`endif
    tick();
    for (int i = 0; i < 3; i++) begin nop(1'b0); tick(); end
  endtask

  task automatic test_forward_chain();
    int n; bit stalled;
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();  // addi x3
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); tick();  // addi x4
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); tick();  // addi x7
    n = 0;
    do begin
      drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);       // add x8,x3,x7
      total++;
      if (obs !== expv) begin bad++; $display("FAIL chain_add n=%0d got=%h exp=%h", n, obs, expv); end
      stalled = exp_ctl[0];
      tick();
      n++;
    end while (stalled && n < 6);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);         // addi x0
    total++;
`ifdef OTTER_HAZARD_FWD_EN
    if ({FWD_A_SEL, FWD_B_SEL} !== 4'b1101) begin
      bad++; $display("FAIL chain_sel got=%b%b required=1101", FWD_A_SEL, FWD_B_SEL);
    end
`else
    if ({n, FWD_A_SEL, FWD_B_SEL} !== {32'd4, 4'b0000}) begin
      bad++; $display("FAIL chain_sel cycles=%0d got=%b%b required 4/0000", n, FWD_A_SEL, FWD_B_SEL);
    end
`endif
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);         // add x9,x0,x0
    total++;
    if (exp_ctl !== 4'b1100 || obs !== expv) begin
      bad++; $display("FAIL x0_nostall got=%h exp=%h", obs, expv);
    end
    tick();
    nop(1'b0);
    total++;
    if ({FWD_A_SEL, FWD_B_SEL} !== 4'b0000) begin
      bad++; $display("FAIL x0_sel got=%b%b required=0000", FWD_A_SEL, FWD_B_SEL);
    end
    tick();
  endtask

  task automatic test_redirect();
    logic [TB_CNT_W-1:0] f0;
    logic [2:0] seen[3];
    f0 = m_flush;
    for (int i = 0; i < 3; i++) begin
      nop(i == 0);
      seen[i] = {IF_DE_FLUSH, DE_EX_BUBBLE, DBG_FLUSH_PEND};
      total++;
      if (obs !== expv) begin bad++; $display("FAIL redirect cyc=%0d got=%h exp=%h", i, obs, expv); end
      tick();
    end
    nop(1'b0);
    total++;
    if ({seen[0], seen[1], seen[2], FLUSH_CNT - f0} !== {3'b110, 3'b111, 3'b000, TB_CNT_W'(1)}) begin
      bad++; $display("FAIL redirect_window got=%b %b %b flushes=%0d required 110 111 000 1",
                      seen[0], seen[1], seen[2], FLUSH_CNT - f0);
    end
    tick();
  endtask

  task automatic test_redirect_load_use();
    logic [TB_CNT_W-1:0] s0;
    s0 = m_stall;
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();  // lw x5
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, (i == 0));
      total++;
      if (obs !== expv || {PC_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE} !== 3'b111) begin
        bad++; $display("FAIL redir_lu cyc=%0d got=%h exp=%h", i, obs, expv);
      end
      tick();
    end
    nop(1'b0);
    total++;
    if (STALL_CNT !== s0 || obs !== expv) begin
      bad++; $display("FAIL redir_lu_cnt stalls=%0d required=%0d", STALL_CNT, s0);
    end
    tick();
  endtask

  task automatic test_back_to_back_redirect();
    for (int i = 0; i < 4; i++) begin
      nop(i < 2);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL b2b_redirect cyc=%0d got=%h exp=%h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv); end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    nop(1'b1); tick();
    RESET = 1'b0;
    nop(1'b0);
    total++;
    if ({PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE} !== 4'b1111) begin
      bad++; $display("FAIL rst_flush_out got=%b required=1111",
                      {PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE});
    end
    tick();
    RESET = 1'b1;
    nop(1'b0);
    total++;
    if ({IF_DE_FLUSH, DBG_FLUSH_PEND, STALL_CNT, FLUSH_CNT} !== '0 || obs !== expv) begin
      bad++; $display("FAIL rst_flush_release flush=%b pend=%b stalls=%0d flushes=%0d required 0",
                      IF_DE_FLUSH, DBG_FLUSH_PEND, STALL_CNT, FLUSH_CNT);
    end
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 700; i++) begin
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);       // lw x5,0(x5)
      total++;
      if (obs !== expv) begin bad++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, obs, expv); end
      tick();
    end
    nop(1'b0);
    total++;
    if (STALL_CNT !== {TB_CNT_W{1'b1}}) begin
      bad++; $display("FAIL saturate_final got=%h required=%h", STALL_CNT, {TB_CNT_W{1'b1}});
    end
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hist.push_back('0);
    m_pend = 1'b0; m_sel = '0; m_stall = '0; m_flush = '0;
    RESET = 1'b0;
    nop(1'b0);
    test_reset();
    test_load_use();
    test_forward_chain();
    test_redirect();
    test_redirect_load_use();
    test_back_to_back_redirect();
    test_random();
    test_reset_mid_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
